// File: rtl/ofm_axi_write_master.sv
// ofm_axi_write_master: drains the 512-bit OFM stream from the convolution
// engine into global memory as AXI4 INCR bursts, one burst in flight at a time.
// Bursts are capped by C_BURST_LEN and never cross a 4KB page.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   xfer_req/addr/size            start pulse, byte address (64B aligned), bytes
//   xfer_done, busy, bresp_err    completion pulse, busy flag, sticky error
//   s_axis_*                      OFM stream input (tvalid/tdata/tready)
//   m_axi_aw*, m_axi_w*, m_axi_b* AXI4 write channels
//
// Optional: define OFM_AXI_WRITE_MASTER_PERF_EN to add the saturating
// perf_busy_cycles / perf_w_stall / perf_src_stall counters.
`timescale 1ns/1ps

module ofm_axi_write_master #(
  parameter int unsigned C_ADDR_WIDTH = 64,
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned C_BURST_LEN  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      xfer_req,
  input  logic [C_ADDR_WIDTH-1:0]   xfer_addr,
  input  logic [C_ADDR_WIDTH-1:0]   xfer_size,
  output logic                      xfer_done,
  output logic                      busy,
  output logic                      bresp_err,
  input  logic                      s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                      s_axis_tready,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp
`ifdef OFM_AXI_WRITE_MASTER_PERF_EN
  ,
  output logic [31:0]               perf_busy_cycles,
  output logic [31:0]               perf_w_stall,
  output logic [31:0]               perf_src_stall
`endif
);

  localparam int unsigned BEAT_BYTES = C_DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
  localparam int unsigned CNT_W      = C_ADDR_WIDTH - OFF_W;
  localparam int unsigned PAGE_BEATS = 4096 / BEAT_BYTES;
  localparam int unsigned PG_W       = $clog2(PAGE_BEATS);
  localparam int unsigned BL_W       = 9;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                  state, state_d;
  logic [C_ADDR_WIDTH-1:0] cur_addr, addr_d;
  logic [CNT_W-1:0]        remaining, rem_d, total_c, page_left_c, burst_w;
  logic [BL_W-1:0]         beat_cnt, bcnt_d, burst_q, burst_c;
  logic                    accept_c, in_data_c, w_hs_c;
  logic                    addr_lo_unused;

  assign addr_lo_unused = ^xfer_addr[OFF_W-1:0];

  // Total beats = ceil(size / beat bytes)
  assign total_c   = CNT_W'(xfer_size[C_ADDR_WIDTH-1:OFF_W]) + CNT_W'(|xfer_size[OFF_W-1:0]);
  assign accept_c  = (state == IDLE) && xfer_req;
  assign in_data_c = (state == DATA);
  assign w_hs_c    = m_axi_wvalid && m_axi_wready;

  // W channel is a direct, state-gated pass-through of the stream
  assign m_axi_wvalid  = in_data_c && s_axis_tvalid;
  assign s_axis_tready = in_data_c && m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = in_data_c && (beat_cnt == BL_W'(1));
  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awsize  = 3'(OFF_W);
  assign m_axi_awburst = 2'b01;

  // Next burst length from the next address/remaining: min(remaining, max, page)
  always_comb begin
    burst_w     = rem_d;
    page_left_c = CNT_W'(PAGE_BEATS) - CNT_W'(addr_d[OFF_W+PG_W-1:OFF_W]);
    if (burst_w > CNT_W'(C_BURST_LEN)) burst_w = CNT_W'(C_BURST_LEN);
    if (burst_w > page_left_c)         burst_w = page_left_c;
    burst_c = BL_W'(burst_w);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state;
    addr_d  = cur_addr;
    rem_d   = remaining;
    bcnt_d  = beat_cnt;
    case (state)
      IDLE: if (xfer_req) begin
        addr_d  = {xfer_addr[C_ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
        rem_d   = total_c;
        state_d = (total_c == '0) ? DONE : ADDR;
      end
      ADDR: if (m_axi_awready) begin
        bcnt_d  = burst_q;
        state_d = DATA;
      end
      DATA: if (w_hs_c) begin
        bcnt_d = beat_cnt - BL_W'(1);
        if (beat_cnt == BL_W'(1)) state_d = RESP;
      end
      RESP: if (m_axi_bvalid) begin
        rem_d   = remaining - CNT_W'(burst_q);
        addr_d  = cur_addr + C_ADDR_WIDTH'({burst_q, OFF_W'(0)});
        state_d = (rem_d != '0) ? ADDR : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath registers and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      burst_q       <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      xfer_done     <= 1'b0;
      busy          <= 1'b0;
      bresp_err     <= 1'b0;
    end else begin
      cur_addr      <= addr_d;
      remaining     <= rem_d;
      beat_cnt      <= bcnt_d;
      // awlen is captured on entry to ADDR so it is stable until awready
      if (state_d == ADDR && state != ADDR) begin
        burst_q     <= burst_c;
        m_axi_awlen <= 8'(burst_c - BL_W'(1));
      end
      m_axi_awvalid <= (state_d == ADDR);
      m_axi_bready  <= (state_d == RESP);
      xfer_done     <= (state == DONE);
      if (accept_c)           busy <= 1'b1;
      else if (state == DONE) busy <= 1'b0;
      if (accept_c)
        bresp_err <= 1'b0;
      else if (state == RESP && m_axi_bvalid && m_axi_bresp != 2'b00)
        bresp_err <= 1'b1;
    end
  end

`ifdef OFM_AXI_WRITE_MASTER_PERF_EN
  // Saturating performance counters, cleared by an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_w_stall     <= '0;
      perf_src_stall   <= '0;
    end else if (accept_c) begin
      perf_busy_cycles <= '0;
      perf_w_stall     <= '0;
      perf_src_stall   <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'(1);
      if (in_data_c && s_axis_tvalid && !m_axi_wready && perf_w_stall != '1)
        perf_w_stall <= perf_w_stall + 32'(1);
      if (in_data_c && !s_axis_tvalid && perf_src_stall != '1)
        perf_src_stall <= perf_src_stall + 32'(1);
    end
  end
`endif

endmodule
